// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - raw input and conditioned outputs of the button debouncer
interface button_debouncer_if;
  logic raw_i;
  logic level_o;
  logic rise_o;
  logic fall_o;
  logic busy_o;

  // Source side: drives the raw contact, observes the conditioned level and strobes
  modport master (
    output raw_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  busy_o
  );

  // Debouncer side
  modport slave (
    input  raw_i,
    output level_o,
    output rise_o,
    output fall_o,
    output busy_o
  );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchronizer plus stability FSM with hold-off counter
module button_debouncer #(
  parameter int STABLE_COUNT = 1000000,
  parameter int COUNT_WIDTH  = 20
) (
  input logic               clk_i,
  input logic               rst_i,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  // Last counter value before a candidate level is accepted
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(STABLE_COUNT - 1);

  logic                   sync1;
  logic                   sync2;
  state_t                 state_q;
  state_t                 state_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   busy_q;
  logic                   busy_d;

  // Bring the asynchronous contact into the clock domain; only sync2 is used below
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.raw_i;
      sync2 <= sync1;
    end
  end

  // State, counter and registered outputs; reset also kills any in-flight strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STABLE_LOW;
      count_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: a change must persist until the counter reaches LAST, any bounce restarts
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (sync2) begin
          state_d = WAIT_HIGH;
          count_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_d = STABLE_LOW;
          count_d = '0;
        end else if (count_q == LAST) begin
          state_d = STABLE_HIGH;
          count_d = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!sync2) begin
          state_d = WAIT_LOW;
          count_d = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_d = STABLE_HIGH;
          count_d = '0;
        end else if (count_q == LAST) begin
          state_d = STABLE_LOW;
          count_d = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        count_d = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign bus.level_o = level_q;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;
  assign bus.busy_o  = busy_q;

endmodule
